// File: rtl/inverter.sv
// Registered two's-complement negation: R = ~A + 1 through an L-bit ripple-carry
// incrementer, one cycle of latency, with optional clamping of the most-negative operand.
module inverter #(
    parameter int L        = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [L-1:0] A,
    output logic         out_valid,
    output logic [L-1:0] R,
    output logic         ovf
);

    logic [L-1:0] w_not;
    logic [L-1:0] w_carry;
    logic [L-1:0] w_sum;
    logic         w_ovf;
    logic [L-1:0] w_result;

    logic         r_valid;
    logic [L-1:0] r_result;
    logic         r_ovf;

    assign w_not      = ~A;
    assign w_carry[0] = 1'b1;

    // Carry out of the top bit is not needed, so the chain stops at bit L-1.
    for (genvar i = 0; i < L; i++) begin : g_ripple
        assign w_sum[i] = w_not[i] ^ w_carry[i];
        if (i < L - 1) begin : g_carry
            assign w_carry[i+1] = w_not[i] & w_carry[i];
        end
    end

    assign w_ovf = A[L-1] & ~(|A[L-2:0]);

    always_comb begin
        w_result = w_sum;
        if (SATURATE && w_ovf) begin
            w_result = {1'b0, {(L-1){1'b1}}};
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_result;
                r_ovf    <= w_ovf;
            end
        end
    end

    assign out_valid = r_valid;
    assign R         = r_result;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_inverter.sv
// Scoreboard bench for inverter: wrap and clamp instances share stimulus; the driver
// queues expected results, the monitor pops and compares whenever out_valid is high.
module tb_inverter;

    typedef struct packed {
        logic [3:0] r;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] A;
    logic       out_valid0, out_valid1;
    logic [3:0] R0, R1;
    logic       ovf0, ovf1;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t hold0 = '0;
    exp_t hold1 = '0;

    always #5 clk = ~clk;

    inverter #(.L(4), .SATURATE(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A),
        .out_valid(out_valid0), .R(R0), .ovf(ovf0)
    );

    inverter #(.L(4), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A),
        .out_valid(out_valid1), .R(R1), .ovf(ovf1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus; expected values come from the caller's hand table.
    task automatic drive(input logic r, input logic v, input logic [3:0] a,
                         input logic [3:0] e0, input logic [3:0] e1, input logic eo);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        A        = a;
        if (v && !r) begin
            q0.push_back('{r: e0, ovf: eo});
            q1.push_back('{r: e1, ovf: eo});
        end
    endtask

    task automatic mon_step(input int id, input logic v, input logic [3:0] r, input logic o);
        exp_t e;
        string tag;
        tag = (id == 0) ? "wrap" : "sat";
        if (rst) begin
            check({tag, " reset out_valid"}, 64'(v), 64'd0);
            check({tag, " reset R"}, 64'(r), 64'd0);
            check({tag, " reset ovf"}, 64'(o), 64'd0);
            if (id == 0) hold0 = '0; else hold1 = '0;
        end else if (v) begin
            if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                check({tag, " unexpected out_valid"}, 64'(v), 64'd0);
            end else begin
                if (id == 0) begin e = q0.pop_front(); hold0 = e; end
                else begin e = q1.pop_front(); hold1 = e; end
                check({tag, " R"}, 64'(r), 64'(e.r));
                check({tag, " ovf"}, 64'(o), 64'(e.ovf));
            end
        end else begin
            e = (id == 0) ? hold0 : hold1;
            check({tag, " hold R"}, 64'(r), 64'(e.r));
            check({tag, " hold ovf"}, 64'(o), 64'(e.ovf));
        end
    endtask

    always @(posedge clk) begin
        #1;
        mon_step(0, out_valid0, R0, ovf0);
        mon_step(1, out_valid1, R1, ovf1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = 4'd0;

        drive(1, 0, 4'h0, 4'h0, 4'h0, 0);
        drive(1, 0, 4'h0, 4'h0, 4'h0, 0);

        // Directed: -1, most-negative, stream 7,5,0
        drive(0, 1, 4'hF, 4'h1, 4'h1, 0);
        drive(0, 1, 4'h8, 4'h8, 4'h7, 1);
        drive(0, 1, 4'h7, 4'h9, 4'h9, 0);
        drive(0, 1, 4'h5, 4'hB, 4'hB, 0);
        drive(0, 1, 4'h0, 4'h0, 4'h0, 0);

        // Hold after A=5: R must stay -5 while idle
        drive(0, 1, 4'h5, 4'hB, 4'hB, 0);
        drive(0, 0, 4'h3, 4'h0, 4'h0, 0);
        drive(0, 0, 4'h8, 4'h0, 4'h0, 0);

        // Operand during reset is discarded, then processed normally
        drive(1, 1, 4'h3, 4'h0, 4'h0, 0);
        drive(0, 1, 4'h3, 4'hD, 4'hD, 0);
        drive(0, 0, 4'h0, 4'h0, 4'h0, 0);

        // Reset right after a result cancels it
        drive(0, 1, 4'h2, 4'hE, 4'hE, 0);
        drive(1, 0, 4'h0, 4'h0, 4'h0, 0);
        drive(0, 0, 4'h0, 4'h0, 4'h0, 0);

        // Exhaustive back-to-back sweep
        for (int i = 0; i < 16; i++) begin
            logic [3:0] a, neg;
            a   = 4'(i);
            neg = 4'(16 - i);
            drive(0, 1, a, neg, (i == 8) ? 4'h7 : neg, i == 8);
        end
        drive(0, 0, 4'h0, 4'h0, 4'h0, 0);
        drive(0, 0, 4'h0, 4'h0, 4'h0, 0);
        @(negedge clk);

        check("wrap queue drained", 64'(q0.size()), 64'd0);
        check("sat queue drained", 64'(q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
